// File: rtl/conv_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer_if
// Bundles the control and handshake signals between the convolution layer
// sequencer and its environment (parameter loader, activation source and the
// conv/pool datapath).
//
// Signals
//   start, load_req          : frame request and "load parameters first" flag
//   prm_valid / prm_ready    : weight + threshold beat handshake
//   in_valid / in_ready      : activation pixel handshake
//   stream_w_en/_addr        : weight memory write strobe and fold address
//   stream_th_en/_addr       : threshold memory write strobe and fold address
//   stream_act_en, act_flush : line-buffer push and zero-pixel injection
//   fold_addr                : output-channel fold currently being computed
//   stream_maxpool_en        : pooling stage enable for the current step
//   out_valid                : datapath output word valid
//   busy, done               : sequencer activity and frame-complete pulse
//
// Modports
//   master : environment side (drives requests and valids)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface conv_layer_sequencer_if #(
  parameter int FOLD_LOG = 1
);
  logic                start;
  logic                load_req;
  logic                prm_valid;
  logic                prm_ready;
  logic                in_valid;
  logic                in_ready;
  logic                stream_w_en;
  logic                stream_th_en;
  logic [FOLD_LOG-1:0] stream_w_addr;
  logic [FOLD_LOG-1:0] stream_th_addr;
  logic                stream_act_en;
  logic                act_flush;
  logic [FOLD_LOG-1:0] fold_addr;
  logic                stream_maxpool_en;
  logic                out_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, load_req, prm_valid, in_valid,
    input  prm_ready, in_ready, stream_w_en, stream_th_en, stream_w_addr,
           stream_th_addr, stream_act_en, act_flush, fold_addr,
           stream_maxpool_en, out_valid, busy, done
  );

  modport slave (
    input  start, load_req, prm_valid, in_valid,
    output prm_ready, in_ready, stream_w_en, stream_th_en, stream_w_addr,
           stream_th_addr, stream_act_en, act_flush, fold_addr,
           stream_maxpool_en, out_valid, busy, done
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer
// Control FSM for one streaming convolution layer. A frame optionally starts
// with a parameter load (one beat per fold, or CH_OUT beats when the layer is
// unfolded), then processes W_IN*W_IN pixels followed by LAG zero-pixel
// flush steps. Every step is WAIT_ACT (1 cycle once a pixel is available),
// COMPUTE (FOLD cycles, one per fold address) and POOL (1 cycle), so the
// steady-state rate is FOLD+2 cycles per step.
//
// Ports
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : conv_layer_sequencer_if.slave, see the interface for signals
// ---------------------------------------------------------------------------
module conv_layer_sequencer #(
  parameter int FOLD       = 1,
  parameter int FOLD_LOG   = (FOLD == 1) ? 1 : $clog2(FOLD),
  parameter int CH_OUT     = 64,
  parameter int W_IN       = 32,
  parameter int LAG        = W_IN + 1,
  parameter int MAXPOOL_EN = 1,
  parameter int POOL_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_layer_sequencer_if.slave bus
);

  localparam int NPIX       = W_IN * W_IN;
  localparam int TOTAL      = NPIX + LAG;
  localparam int STEP_W     = $clog2(TOTAL + 1);
  localparam int LOAD_DEPTH = (FOLD == 1) ? CH_OUT : FOLD;
  localparam int BEAT_W     = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int POS_W      = (W_IN > 1) ? $clog2(W_IN) : 1;

  localparam logic [STEP_W-1:0]   STEP_NPIX = STEP_W'(NPIX);
  localparam logic [STEP_W-1:0]   STEP_LAG  = STEP_W'(LAG);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(TOTAL - 1);
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(LOAD_DEPTH - 1);
  localparam logic [FOLD_LOG-1:0] FOLD_LAST = FOLD_LOG'(FOLD - 1);
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(W_IN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACT,
    COMPUTE,
    POOL,
    DONE
  } stateT;

  stateT               state_q;
  logic [STEP_W-1:0]   stepCnt_q;
  logic [BEAT_W-1:0]   beatCnt_q;
  logic [FOLD_LOG-1:0] foldCnt_q;
  logic [POS_W-1:0]    row_q;
  logic [POS_W-1:0]    col_q;
  logic [POOL_LAT-1:0] poolPipe_q;

  logic inLoad;
  logic inWait;
  logic inCompute;
  logic inPool;
  logic pixPhase;
  logic pastLag;
  logic prmBeat;
  logic poolTrigger;

  // State decode shared by the output equations and the FSM. pixPhase marks
  // steps that consume a real pixel; later steps are flush steps. pastLag
  // means the conv output for this step is meaningful (step >= LAG).
  assign inLoad    = (state_q == LOAD);
  assign inWait    = (state_q == WAIT_ACT);
  assign inCompute = (state_q == COMPUTE);
  assign inPool    = (state_q == POOL);
  assign pixPhase  = (stepCnt_q < STEP_NPIX);
  assign pastLag   = (stepCnt_q >= STEP_LAG);
  assign prmBeat   = inLoad & bus.prm_valid;

  // A 2x2 stride-2 pooling window completes on the conv output whose row
  // and column are both odd, so only those POOL cycles launch a pulse down
  // the pooling latency delay line.
  assign poolTrigger = inPool & pastLag & row_q[0] & col_q[0];

  // Output decode. Everything except the handshake-qualified strobes is a
  // function of registered state, so reset drives every output low on the
  // following cycle. Write addresses sit at 0 for an unfolded layer.
  assign bus.prm_ready         = inLoad;
  assign bus.stream_w_en       = prmBeat;
  assign bus.stream_th_en      = prmBeat;
  assign bus.stream_w_addr     = (inLoad && FOLD != 1) ? FOLD_LOG'(beatCnt_q) : '0;
  assign bus.stream_th_addr    = (inLoad && FOLD != 1) ? FOLD_LOG'(beatCnt_q) : '0;
  assign bus.in_ready          = inWait & pixPhase;
  assign bus.stream_act_en     = inWait & (pixPhase ? bus.in_valid : 1'b1);
  assign bus.act_flush         = inWait & ~pixPhase;
  assign bus.fold_addr         = inCompute ? foldCnt_q : '0;
  assign bus.stream_maxpool_en = inPool & pastLag;
  assign bus.out_valid         = (MAXPOOL_EN != 0) ? poolPipe_q[POOL_LAT-1]
                                                   : (inPool & pastLag);
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == DONE);

  // Main sequencer: state, step/beat/fold counters, conv output position and
  // the pooling delay line. The delay line shifts in every non-reset cycle
  // so a pulse launched by the last POOL still emerges after DONE. A reset
  // mid-LOAD leaves already written parameters in place; the next frame
  // must request a fresh load if it needs consistent parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      stepCnt_q  <= '0;
      beatCnt_q  <= '0;
      foldCnt_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      poolPipe_q <= '0;
    end else begin
      poolPipe_q[0] <= poolTrigger;
      for (int i = 1; i < POOL_LAT; i++) begin
        poolPipe_q[i] <= poolPipe_q[i-1];
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            stepCnt_q <= '0;
            beatCnt_q <= '0;
            foldCnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            state_q   <= bus.load_req ? LOAD : WAIT_ACT;
          end
        end

        LOAD: begin
          if (prmBeat) begin
            if (beatCnt_q == BEAT_LAST) begin
              beatCnt_q <= '0;
              state_q   <= WAIT_ACT;
            end else begin
              beatCnt_q <= beatCnt_q + BEAT_W'(1);
            end
          end
        end

        WAIT_ACT: begin
          if (!pixPhase || bus.in_valid) begin
            state_q <= COMPUTE;
          end
        end

        COMPUTE: begin
          if (foldCnt_q == FOLD_LAST) begin
            foldCnt_q <= '0;
            state_q   <= POOL;
          end else begin
            foldCnt_q <= foldCnt_q + FOLD_LOG'(1);
          end
        end

        POOL: begin
          stepCnt_q <= stepCnt_q + STEP_W'(1);
          if (pastLag) begin
            if (col_q == POS_LAST) begin
              col_q <= '0;
              row_q <= (row_q == POS_LAST) ? '0 : row_q + POS_W'(1);
            end else begin
              col_q <= col_q + POS_W'(1);
            end
          end
          state_q <= (stepCnt_q == STEP_LAST) ? DONE : WAIT_ACT;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sequencer
// Three sequencer instances share one stimulus stream:
//   dutP : FOLD=4, W_IN=4, LAG=5, pooling absent
//   dutM : same geometry, pooling present, POOL_LAT=2
//   dutC : FOLD=1, CH_OUT=8 (unfolded parameter load)
// Frame runs come from a table of records; expected pulse cycles are pushed
// into queues when a frame is launched and popped by the output monitor.
// ---------------------------------------------------------------------------
module tb_conv_layer_sequencer;

  localparam int STEP_CYC = 6;
  localparam int NSTEPS   = 21;
  localparam int TB_LAG   = 5;
  localparam int TB_W     = 4;

  logic clk = 1'b0;
  logic reset;
  logic startS;
  logic loadReqS;
  logic prmValidS;
  logic inValidS;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int startCyc;

  int qOutP[$];
  int qOutM[$];
  int qDoneP[$];
  int qWrP[$];
  int qWrC[$];
  int outCountP;
  int outCountM;
  int doneCountP;
  int doneCycP;
  int wrCountP;
  int wrCountC;

  typedef struct {
    int stallStep;
    int stallLen;
    bit glitch;
    int expCycles;
    int expOutP;
    int expOutM;
  } frameVecT;

  frameVecT vecs[4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_sequencer_if #(.FOLD_LOG(2)) ifP ();
  conv_layer_sequencer_if #(.FOLD_LOG(2)) ifM ();
  conv_layer_sequencer_if #(.FOLD_LOG(1)) ifC ();

  assign ifP.start = startS;
  assign ifP.load_req = loadReqS;
  assign ifP.prm_valid = prmValidS;
  assign ifP.in_valid = inValidS;
  assign ifM.start = startS;
  assign ifM.load_req = loadReqS;
  assign ifM.prm_valid = prmValidS;
  assign ifM.in_valid = inValidS;
  assign ifC.start = startS;
  assign ifC.load_req = loadReqS;
  assign ifC.prm_valid = prmValidS;
  assign ifC.in_valid = inValidS;

  conv_layer_sequencer #(
    .FOLD(4), .CH_OUT(64), .W_IN(4), .LAG(5), .MAXPOOL_EN(0), .POOL_LAT(2)
  ) dutP (.clk(clk), .reset(reset), .bus(ifP));

  conv_layer_sequencer #(
    .FOLD(4), .CH_OUT(64), .W_IN(4), .LAG(5), .MAXPOOL_EN(1), .POOL_LAT(2)
  ) dutM (.clk(clk), .reset(reset), .bus(ifM));

  conv_layer_sequencer #(
    .FOLD(1), .CH_OUT(8), .W_IN(4), .LAG(5), .MAXPOOL_EN(0), .POOL_LAT(2)
  ) dutC (.clk(clk), .reset(reset), .bus(ifC));

  logic [15:0] allP;
  logic [15:0] allM;
  logic [12:0] allC;

  assign allP = {ifP.prm_ready, ifP.in_ready, ifP.stream_w_en, ifP.stream_th_en,
                 ifP.stream_w_addr, ifP.stream_th_addr, ifP.stream_act_en,
                 ifP.act_flush, ifP.fold_addr, ifP.stream_maxpool_en,
                 ifP.out_valid, ifP.busy, ifP.done};
  assign allM = {ifM.prm_ready, ifM.in_ready, ifM.stream_w_en, ifM.stream_th_en,
                 ifM.stream_w_addr, ifM.stream_th_addr, ifM.stream_act_en,
                 ifM.act_flush, ifM.fold_addr, ifM.stream_maxpool_en,
                 ifM.out_valid, ifM.busy, ifM.done};
  assign allC = {ifC.prm_ready, ifC.in_ready, ifC.stream_w_en, ifC.stream_th_en,
                 ifC.stream_w_addr, ifC.stream_th_addr, ifC.stream_act_en,
                 ifC.act_flush, ifC.fold_addr, ifC.stream_maxpool_en,
                 ifC.out_valid, ifC.busy, ifC.done};

  // One comparison: counts it, and reports it when actual differs.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Output monitor: every observed pulse pops the scoreboard entry that the
  // stimulus side pushed for it and compares cycle or address.
  always @(negedge clk) begin
    if (ifP.out_valid) begin
      outCountP++;
      if (qOutP.size() == 0) checkOutput("unexpected_out_p", cyc, -1);
      else checkOutput("out_p_cycle", cyc, qOutP.pop_front());
    end
    if (ifM.out_valid) begin
      outCountM++;
      if (qOutM.size() == 0) checkOutput("unexpected_out_m", cyc, -1);
      else checkOutput("out_m_cycle", cyc, qOutM.pop_front());
    end
    if (ifP.done) begin
      doneCountP++;
      doneCycP = cyc;
      if (qDoneP.size() == 0) checkOutput("unexpected_done_p", cyc, -1);
      else checkOutput("done_p_cycle", cyc, qDoneP.pop_front());
    end
    if (ifP.stream_w_en) begin
      wrCountP++;
      if (qWrP.size() == 0) checkOutput("unexpected_wr_p", int'(ifP.stream_w_addr), -1);
      else begin
        int e;
        e = qWrP.pop_front();
        checkOutput("wr_addr_p", int'(ifP.stream_w_addr), e);
        checkOutput("th_addr_p", int'({ifP.stream_th_en, ifP.stream_th_addr}), 4 + e);
      end
    end
    if (ifC.stream_w_en) begin
      wrCountC++;
      if (qWrC.size() == 0) checkOutput("unexpected_wr_c", int'(ifC.stream_w_addr), -1);
      else begin
        int e;
        e = qWrC.pop_front();
        checkOutput("wr_addr_c", int'({ifC.stream_th_en, ifC.stream_w_addr, ifC.stream_th_addr}), 4 + 2 * e + e);
      end
    end
  end

  task automatic startFrame(input bit ld);
    loadReqS = ld;
    startS = 1'b1;
    @(posedge clk); #1;
    startCyc = cyc;
    startS = 1'b0;
    loadReqS = 1'b0;
  endtask

  // Runs one frame described by a table record and checks it.
  task automatic applyStimulus(input frameVecT v, input string tag);
    int k;
    int add;
    int pc;
    int n;
    int flushCyc;
    outCountP = 0;
    outCountM = 0;
    doneCountP = 0;
    inValidS = 1'b1;
    startFrame(1'b0);
    k = startCyc;
    for (int s = 0; s < NSTEPS; s++) begin
      add = (v.stallStep >= 0 && s >= v.stallStep) ? v.stallLen : 0;
      pc = k + STEP_CYC * s + 5 + add;
      if (s >= TB_LAG) begin
        qOutP.push_back(pc);
        n = s - TB_LAG;
        if (((n / TB_W) % 2 == 1) && ((n % TB_W) % 2 == 1)) qOutM.push_back(pc + 2);
      end
    end
    add = (v.stallStep >= 0) ? v.stallLen : 0;
    qDoneP.push_back(k + STEP_CYC * NSTEPS + add);
    flushCyc = k + STEP_CYC * 16 + ((v.stallStep >= 0 && v.stallStep <= 16) ? v.stallLen : 0);

    @(negedge clk);
    checkOutput({tag, "_first_wait"}, int'({ifP.in_ready, ifP.stream_act_en, ifP.act_flush}), 6);

    while (doneCountP == 0 && cyc < k + 400) begin
      @(posedge clk); #1;
      if (v.glitch && (cyc == k + 6 || cyc == k + 8)) begin
        startS = 1'b1;
        loadReqS = 1'b1;
      end else begin
        startS = 1'b0;
        loadReqS = 1'b0;
      end
      if (v.stallStep >= 0 && cyc == k + STEP_CYC * v.stallStep) begin
        inValidS = 1'b0;
        for (int i = 0; i < v.stallLen; i++) begin
          @(negedge clk);
          checkOutput({tag, "_stall_hold"},
                      int'({ifP.busy, ifP.in_ready, ifP.stream_act_en, ifP.fold_addr}), 24);
          @(posedge clk); #1;
        end
        inValidS = 1'b1;
      end
      if (cyc == flushCyc) begin
        @(negedge clk);
        checkOutput({tag, "_flush"}, int'({ifP.in_ready, ifP.stream_act_en, ifP.act_flush}), 3);
      end
    end
    startS = 1'b0;
    loadReqS = 1'b0;

    if (doneCountP == 0) checkOutput({tag, "_timeout"}, 0, 1);
    else checkOutput({tag, "_cycles"}, doneCycP - k, v.expCycles);

    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_out_count_p"}, outCountP, v.expOutP);
    checkOutput({tag, "_out_count_m"}, outCountM, v.expOutM);
    checkOutput({tag, "_done_count"}, doneCountP, 1);
    checkOutput({tag, "_left_p"}, qOutP.size() + qDoneP.size(), 0);
    checkOutput({tag, "_left_m"}, qOutM.size(), 0);
    checkOutput({tag, "_idle_busy"}, int'({ifP.busy, ifM.busy, ifC.busy}), 0);
    qOutP.delete();
    qOutM.delete();
    qDoneP.delete();
  endtask

  initial begin
    vecs[0] = '{-1, 0, 1'b0, 126, 16, 4};
    vecs[1] = '{7, 3, 1'b0, 129, 16, 4};
    vecs[2] = '{-1, 0, 1'b1, 126, 16, 4};
    vecs[3] = '{-1, 0, 1'b0, 126, 16, 4};

    reset = 1'b1;
    startS = 1'b0;
    loadReqS = 1'b0;
    prmValidS = 1'b0;
    inValidS = 1'b0;
    outCountP = 0;
    outCountM = 0;
    doneCountP = 0;
    doneCycP = 0;
    wrCountP = 0;
    wrCountC = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("reset_all_p", int'(allP), 0);
    checkOutput("reset_all_m", int'(allM), 0);
    checkOutput("reset_all_c", int'(allC), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Parameter load with prm_valid toggling; extra beats after the load
    // finishes must not produce writes.
    $display("[TB] parameter load");
    for (int i = 0; i < 4; i++) qWrP.push_back(i);
    for (int i = 0; i < 8; i++) qWrC.push_back(0);
    startFrame(1'b1);
    for (int i = 0; i < 18; i++) begin
      prmValidS = (i % 2 == 0);
      @(posedge clk); #1;
    end
    prmValidS = 1'b0;
    @(negedge clk);
    checkOutput("load_end_p", int'({ifP.prm_ready, ifP.in_ready, ifP.busy}), 3);
    checkOutput("load_end_c", int'({ifC.prm_ready, ifC.in_ready, ifC.busy}), 3);
    checkOutput("load_wr_count_p", wrCountP, 4);
    checkOutput("load_wr_count_c", wrCountC, 8);
    checkOutput("load_left", qWrP.size() + qWrC.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;

    for (int r = 0; r < 3; r++) begin
      $display("[TB] frame vector %0d", r);
      applyStimulus(vecs[r], $sformatf("vec%0d", r));
    end

    // Reset in the middle of COMPUTE, then a clean rerun.
    $display("[TB] reset during compute");
    inValidS = 1'b1;
    startFrame(1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("fold_before_reset", int'(ifP.fold_addr), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midreset_all_p", int'(allP), 0);
    checkOutput("midreset_all_m", int'(allM), 0);
    checkOutput("midreset_all_c", int'(allC), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(vecs[3], "rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
